// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the VGA sync generator to the pixel generator.
interface vga_sync_gen_if;
    logic       pix_clk;
    logic       ref_tick;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       hsync;
    logic       vsync;

    modport master (output pix_clk, ref_tick, video_on, pix_x, pix_y, hsync, vsync);
    modport slave  (input  pix_clk, ref_tick, video_on, pix_x, pix_y, hsync, vsync);
endinterface

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: pixel enable, counters, syncs, frame tick.
// Optional VGA_SYNC_DELAY_EN adds one pixel of lag on hsync/vsync only.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_clk;
    logic [9:0]       pix_x, pix_y;
    logic [9:0]       x_next, y_next;
    logic             hsync_q, vsync_q, video_on, ref_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pix_clk <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            pix_clk <= (div_cnt == DIV_LAST);
        end
    end

    always_comb begin
        x_next = pix_x;
        y_next = pix_y;
        if (pix_clk) begin
            if (pix_x == H_LAST) begin
                x_next = '0;
                y_next = (pix_y == V_LAST) ? '0 : pix_y + 10'd1;
            end else begin
                x_next = pix_x + 10'd1;
            end
        end
    end

    // Flags decode the next coordinates so they land on the same edge as pix_x/pix_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_x    <= '0;
            pix_y    <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            video_on <= 1'b1;
            ref_tick <= 1'b0;
        end else begin
            pix_x    <= x_next;
            pix_y    <= y_next;
            hsync_q  <= !((x_next >= HS_START) && (x_next < HS_END));
            vsync_q  <= !((y_next >= VS_START) && (y_next < VS_END));
            video_on <= (x_next < H_VIS) && (y_next < V_VIS);
            ref_tick <= pix_clk && (x_next == '0) && (y_next == V_VIS);
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hsync_d, vsync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_d <= 1'b1;
            vsync_d <= 1'b1;
        end else if (pix_clk) begin
            hsync_d <= hsync_q;
            vsync_d <= vsync_q;
        end
    end

    assign vga.hsync = hsync_d;
    assign vga.vsync = vsync_d;
`else
    assign vga.hsync = hsync_q;
    assign vga.vsync = vsync_q;
`endif

    assign vga.pix_clk  = pix_clk;
    assign vga.ref_tick = ref_tick;
    assign vga.video_on = video_on;
    assign vga.pix_x    = pix_x;
    assign vga.pix_y    = pix_y;

endmodule
